// File: rtl/regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl
//   Sequences binary-indexed READ / WRITE / MOVE (and optionally SWAP) requests
//   from instruction decode into per-cycle accesses on a one-hot register file
//   interface (RegNum / RegCE / A in, rf_out back), then returns a response.
//
//   Optional feature macro: RFCTRL_SWAP_EN
//     defined   : op 2'b11 is SWAP (RD_A, RD_B, WR_A, WR_B); tmp_b is built.
//     undefined : op 2'b11 is illegal, answered after one edge with rsp_err=1.
//
// Ports
//   clk, nReset            clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; ready only in IDLE
//   req_op                 00 READ, 01 WRITE, 10 MOVE, 11 SWAP/illegal
//   req_src/req_dst        register indices, req_wdata write data
//   rsp_valid/rsp_ready    response handshake; response held until consumed
//   rsp_data/rsp_err       response payload / illegal-request flag
//   RegNum                 one-hot register select (0 when not accessing)
//   RegCE                  register-file write enable
//   A                      register-file write data
//   rf_out                 register-file read data (combinational on RegNum)
// ----------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter  int DW   = 8,
    parameter  int NREG = 4,
    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [IDXW-1:0] req_src,
    input  logic [IDXW-1:0] req_dst,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic [NREG-1:0] RegNum,
    output logic            RegCE,
    output logic [DW-1:0]   A,
    input  logic [DW-1:0]   rf_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    // Register count at index width + 1 so the range check never truncates.
    localparam logic [IDXW:0]   NREG_L = (IDXW + 1)'(NREG);
    localparam logic [NREG-1:0] OH_ONE = {{(NREG-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
`ifdef RFCTRL_SWAP_EN
        S_RD_B,
        S_WR_B,
`endif
        S_WR_A,
        S_RESP
    } state_t;

    state_t          state, state_d;

    logic [1:0]      op_q;
    logic [IDXW-1:0] src_q, dst_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   tmp_a;
`ifdef RFCTRL_SWAP_EN
    logic [DW-1:0]   tmp_b;
`endif

    logic            src_ok, dst_ok, legal;
    logic [NREG-1:0] oh_src, oh_dst;

    assign oh_src = OH_ONE << src_q;
    assign oh_dst = OH_ONE << dst_q;

    // Legality of the request currently offered on the req_* bus.
    always_comb begin
        src_ok = ({1'b0, req_src} < NREG_L);
        dst_ok = ({1'b0, req_dst} < NREG_L);
        legal  = 1'b0;
        case (req_op)
            OP_READ:  legal = src_ok;
            OP_WRITE: legal = dst_ok;
            OP_MOVE:  legal = src_ok && dst_ok;
            OP_SWAP: begin
`ifdef RFCTRL_SWAP_EN
                legal = src_ok && dst_ok;
`else
                legal = 1'b0;
`endif
            end
        endcase
    end

    // State register. Outputs below decode from state, so an async reset
    // drops RegCE in the same instant and no partial write can land.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next state and register-file interface outputs.
    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        RegNum    = '0;
        RegCE     = 1'b0;
        A         = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!legal)                state_d = S_RESP;
                    else if (req_op == OP_WRITE) state_d = S_WR_A;
                    else                       state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                RegNum = oh_src;
                if (op_q == OP_READ) state_d = S_RESP;
`ifdef RFCTRL_SWAP_EN
                else if (op_q == OP_SWAP) state_d = S_RD_B;
`endif
                else                 state_d = S_WR_A;
            end
`ifdef RFCTRL_SWAP_EN
            S_RD_B: begin
                RegNum  = oh_dst;
                state_d = S_WR_A;
            end
            S_WR_B: begin
                RegNum  = oh_dst;
                RegCE   = 1'b1;
                A       = tmp_a;
                state_d = S_RESP;
            end
`endif
            S_WR_A: begin
                RegCE   = 1'b1;
                RegNum  = oh_dst;
                A       = (op_q == OP_WRITE) ? wdata_q : tmp_a;
                state_d = S_RESP;
`ifdef RFCTRL_SWAP_EN
                // SWAP writes the source first with the old destination value.
                if (op_q == OP_SWAP) begin
                    RegNum  = oh_src;
                    A       = tmp_b;
                    state_d = S_WR_B;
                end
`endif
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, read temporaries and response payload. Nothing here
    // changes in RESP, so the payload is stable while the response waits.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            op_q     <= OP_READ;
            src_q    <= '0;
            dst_q    <= '0;
            wdata_q  <= '0;
            tmp_a    <= '0;
`ifdef RFCTRL_SWAP_EN
            tmp_b    <= '0;
`endif
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        src_q    <= req_src;
                        dst_q    <= req_dst;
                        wdata_q  <= req_wdata;
                        rsp_err  <= !legal;
                        rsp_data <= (legal && req_op == OP_WRITE) ? req_wdata : '0;
                    end
                end
                S_RD_A: begin
                    // Old source value is the response for READ, MOVE and SWAP.
                    tmp_a    <= rf_out;
                    rsp_data <= rf_out;
                end
`ifdef RFCTRL_SWAP_EN
                S_RD_B: tmp_b <= rf_out;
`endif
                default: ;
            endcase
        end
    end

endmodule
